// File: rtl/pwm_pkg.sv
// Shared types and default constants for the multi-channel PWM block.
package pwm_pkg;

  typedef enum logic {
    PWM_EDGE,
    PWM_CENTER
  } pwm_mode_e;

  localparam int PWM_PERIOD_DFLT   = 606;
  localparam int PWM_SCALE_DFLT    = 3;
  localparam int PWM_DUTY_MAX_DFLT = 200;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: saturating command scaler, pending/active double
// buffer latched at the period boundary, and edge/centre comparator.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int DUTY_W   = 8,
  parameter int CNT_W    = 10,
  parameter int PERIOD   = PWM_PERIOD_DFLT,
  parameter int SCALE    = PWM_SCALE_DFLT,
  parameter int DUTY_MAX = PWM_DUTY_MAX_DFLT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  cnt,
  input  logic              boundary,
  input  pwm_mode_e         mode_q,
  input  logic [DUTY_W-1:0] duty,
  input  logic              duty_valid,
  input  logic              ch_en,
  input  logic              sat_clr,
  output logic              pwm,
  output logic              sat
);

  logic [CNT_W-1:0] pending;
  logic [CNT_W-1:0] active;
  logic [CNT_W-1:0] lo;
  logic [CNT_W-1:0] clip;
  logic [CNT_W-1:0] cmd;
  logic [CNT_W-1:0] lo_nxt;
  logic [CNT_W:0]   hi_end;
  logic             en_q;
  logic             over;
  logic             hit;

  assign over   = duty > DUTY_W'(DUTY_MAX);
  assign clip   = over ? CNT_W'(DUTY_MAX) : CNT_W'(duty);
  assign cmd    = clip * CNT_W'(SCALE);
  // Centre the high window; odd slack leaves the extra low cycle at the end.
  assign lo_nxt = (CNT_W'(PERIOD) - pending) >> 1;
  assign hi_end = {1'b0, lo} + {1'b0, active};

  always_comb begin
    hit = 1'b0;
    unique case (mode_q)
      PWM_EDGE:   hit = cnt < active;
      PWM_CENTER: hit = (cnt >= lo) && ({1'b0, cnt} < hi_end);
      default:    hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      active  <= '0;
      lo      <= '0;
      en_q    <= 1'b0;
      sat     <= 1'b0;
      pwm     <= 1'b0;
    end else begin
      if (duty_valid)
        pending <= cmd;
      if (boundary) begin
        active <= pending;
        lo     <= lo_nxt;
        en_q   <= ch_en;
      end
      if (duty_valid && over)
        sat <= 1'b1;
      else if (sat_clr)
        sat <= 1'b0;
      pwm <= en_q & hit;
    end
  end

endmodule

// File: rtl/pwm_multi_speed.sv
// Multi-channel PWM: shared period counter, boundary decode and
// mode register driving NUM_CH independent duty channels.
module pwm_multi_speed
  import pwm_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int DUTY_W   = 8,
  parameter int CNT_W    = 10,
  parameter int PERIOD   = PWM_PERIOD_DFLT,
  parameter int SCALE    = PWM_SCALE_DFLT,
  parameter int DUTY_MAX = PWM_DUTY_MAX_DFLT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DUTY_W-1:0] duty_in,
  input  logic [NUM_CH-1:0]        duty_valid,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic                     mode_center,
  input  logic                     sat_clr,
  output logic [NUM_CH-1:0]        pwm_out,
  output logic                     period_start,
  output logic [NUM_CH-1:0]        duty_sat
);

  if (DUTY_MAX * SCALE > PERIOD) begin : g_bad_scale
    $error("DUTY_MAX*SCALE exceeds PERIOD");
  end
  if (PERIOD > 2 ** CNT_W) begin : g_bad_cnt
    $error("PERIOD does not fit in CNT_W");
  end

  logic [CNT_W-1:0] cnt;
  logic             boundary;
  pwm_mode_e        mode_q;

  assign boundary = cnt == CNT_W'(PERIOD - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      mode_q       <= PWM_EDGE;
      period_start <= 1'b0;
    end else begin
      cnt          <= boundary ? '0 : cnt + CNT_W'(1);
      period_start <= cnt == '0;
      if (boundary)
        mode_q <= mode_center ? PWM_CENTER : PWM_EDGE;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pwm_channel #(
      .DUTY_W   (DUTY_W),
      .CNT_W    (CNT_W),
      .PERIOD   (PERIOD),
      .SCALE    (SCALE),
      .DUTY_MAX (DUTY_MAX)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .cnt        (cnt),
      .boundary   (boundary),
      .mode_q     (mode_q),
      .duty       (duty_in[g*DUTY_W +: DUTY_W]),
      .duty_valid (duty_valid[g]),
      .ch_en      (ch_en[g]),
      .sat_clr    (sat_clr),
      .pwm        (pwm_out[g]),
      .sat        (duty_sat[g])
    );
  end

endmodule

// File: tb/tb_pwm_multi_speed.sv
// Scoreboard bench: per-period expectations queued by stimulus,
// checked by a monitor that measures each output period.
module tb_pwm_multi_speed;

  localparam int NCH = 4;
  localparam int PER = 606;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [31:0]    duty_in = '0;
  logic [NCH-1:0] duty_valid = '0;
  logic [NCH-1:0] ch_en = '0;
  logic           mode_center = 1'b0;
  logic           sat_clr = 1'b0;
  logic [NCH-1:0] pwm_out;
  logic           period_start;
  logic [NCH-1:0] duty_sat;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [3:0][11:0] hi;
    logic [3:0][11:0] fst;
    logic [3:0]       sat;
  } exp_t;

  exp_t exp_q[$];

  pwm_multi_speed dut (
    .clk          (clk),
    .rst          (rst),
    .duty_in      (duty_in),
    .duty_valid   (duty_valid),
    .ch_en        (ch_en),
    .mode_center  (mode_center),
    .sat_clr      (sat_clr),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .duty_sat     (duty_sat)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endfunction

  function automatic exp_t mk(int h0, int h1, int h2, int h3,
                              int f0, int f1, int f2, int f3,
                              logic [3:0] s);
    exp_t e;
    e.hi[0]  = 12'(h0);
    e.hi[1]  = 12'(h1);
    e.hi[2]  = 12'(h2);
    e.hi[3]  = 12'(h3);
    e.fst[0] = 12'(f0);
    e.fst[1] = 12'(f1);
    e.fst[2] = 12'(f2);
    e.fst[3] = 12'(f3);
    e.sat    = s;
    return e;
  endfunction

  // Monitor: one record per output period, framed by period_start.
  int         m_len;
  int         m_hi[NCH];
  int         m_fst[NCH];
  int         m_pidx = 0;
  logic [3:0] m_sat;
  bit         m_inp = 1'b0;

  function automatic void finalize();
    exp_t e;
    int   ef;
    if (exp_q.size() == 0) begin
      chk($sformatf("p%0d expectation present", m_pidx), 0, 1);
      return;
    end
    e = exp_q.pop_front();
    chk($sformatf("p%0d period_len", m_pidx), m_len, PER);
    for (int c = 0; c < NCH; c++) begin
      ef = (e.fst[c] == 12'hFFF) ? -1 : int'(e.fst[c]);
      chk($sformatf("p%0d ch%0d high_cycles", m_pidx, c),
          m_hi[c], int'(e.hi[c]));
      chk($sformatf("p%0d ch%0d first_high", m_pidx, c),
          m_fst[c], ef);
    end
    chk($sformatf("p%0d duty_sat", m_pidx), int'(m_sat), int'(e.sat));
    m_pidx++;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      m_inp = 1'b0;
    end else begin
      if (period_start) begin
        if (m_inp)
          finalize();
        m_inp = 1'b1;
        m_len = 0;
        m_sat = duty_sat;
        for (int c = 0; c < NCH; c++) begin
          m_hi[c]  = 0;
          m_fst[c] = -1;
        end
      end
      if (m_inp) begin
        for (int c = 0; c < NCH; c++) begin
          if (pwm_out[c]) begin
            if (m_fst[c] < 0)
              m_fst[c] = m_len;
            m_hi[c]++;
          end
        end
        m_len++;
      end
    end
  end

  task automatic wait_ps(output int n);
    for (int i = 1; i <= 700; i++) begin
      @(negedge clk);
      if (period_start) begin
        n = i;
        return;
      end
    end
    $display("FAIL wait_ps: no period_start within 700 cycles");
    $fatal(1, "period_start timeout");
  endtask

  // Called at a period_start negedge; returns at the next one.
  task automatic run_vec(logic [3:0] en, logic md, logic clr,
                         logic [3:0] ma, logic [31:0] da, int oa,
                         logic [3:0] mb, logic [31:0] db, int ob,
                         exp_t e);
    int n;
    exp_q.push_back(e);
    ch_en       = en;
    mode_center = md;
    sat_clr     = clr;
    if (oa == 0) begin
      duty_valid = ma;
      duty_in    = da;
    end
    for (int o = 1; o < PER; o++) begin
      @(negedge clk);
      duty_valid = '0;
      sat_clr    = 1'b0;
      if (o == oa) begin
        duty_valid = ma;
        duty_in    = da;
      end
      if (o == ob) begin
        duty_valid = mb;
        duty_in    = db;
      end
    end
    wait_ps(n);
    chk("period_spacing", n, 1);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("reset pwm_out", int'(pwm_out), 0);
    chk("reset period_start", int'(period_start), 0);
    chk("reset duty_sat", int'(duty_sat), 0);
    exp_q.push_back(mk(0, 0, 0, 0, -1, -1, -1, -1, 4'b0000));
    rst = 1'b0;
    wait_ps(n);
    chk("first period_start delay", n, 1);

    // ch0 = 100 -> 300 high, edge aligned
    run_vec(4'hF, 1'b0, 1'b0, 4'b0001, 32'h0000_0064, 0, 4'b0, 32'h0, -1,
            mk(300, 0, 0, 0, 0, -1, -1, -1, 4'b0000));
    // ch1 = 255 saturates to 600
    run_vec(4'hF, 1'b0, 1'b0, 4'b0010, 32'h0000_FF00, 0, 4'b0, 32'h0, -1,
            mk(300, 600, 0, 0, 0, 0, -1, -1, 4'b0010));
    // clear and set in the same cycle: set wins
    run_vec(4'hF, 1'b0, 1'b1, 4'b0010, 32'h0000_FF00, 0, 4'b0, 32'h0, -1,
            mk(300, 600, 0, 0, 0, 0, -1, -1, 4'b0010));
    // clear alone, switch to centre mode
    run_vec(4'hF, 1'b1, 1'b1, 4'b0000, 32'h0, -1, 4'b0, 32'h0, -1,
            mk(300, 600, 0, 0, 153, 3, -1, -1, 4'b0000));
    // ch2: 50 then 80 within one period, ch3 disabled
    run_vec(4'h7, 1'b1, 1'b0, 4'b1100, 32'h0A32_0000, 0,
            4'b0100, 32'h0050_0000, 100,
            mk(300, 600, 240, 0, 153, 3, 183, -1, 4'b0000));
    // load in the boundary cycle applies one period later
    run_vec(4'hF, 1'b0, 1'b0, 4'b0001, 32'h0000_0014, 604,
            4'b0, 32'h0, -1,
            mk(300, 600, 240, 30, 0, 0, 0, 0, 4'b0000));
    run_vec(4'hF, 1'b0, 1'b0, 4'b0000, 32'h0, -1, 4'b0, 32'h0, -1,
            mk(60, 600, 240, 30, 0, 0, 0, 0, 4'b0000));
    // ch0 at ceiling without saturation, ch1 to zero
    run_vec(4'hF, 1'b0, 1'b0, 4'b0011, 32'h0000_00C8, 0, 4'b0, 32'h0, -1,
            mk(600, 0, 240, 30, 0, -1, 0, 0, 4'b0000));
    run_vec(4'hF, 1'b0, 1'b0, 4'b0000, 32'h0, -1, 4'b0, 32'h0, -1,
            mk(600, 0, 240, 30, 0, -1, 0, 0, 4'b0000));

    // Mid-period reset with ch0 high and a load in flight.
    repeat (20) @(negedge clk);
    chk("ch0 high before reset", int'(pwm_out[0]), 1);
    duty_valid = 4'b0001;
    duty_in    = 32'h0000_00FF;
    @(negedge clk);
    duty_valid = '0;
    chk("sat set before reset", int'(duty_sat), 1);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("mid reset pwm_out", int'(pwm_out), 0);
    chk("mid reset period_start", int'(period_start), 0);
    chk("mid reset duty_sat", int'(duty_sat), 0);
    repeat (2) @(negedge clk);
    exp_q.push_back(mk(0, 0, 0, 0, -1, -1, -1, -1, 4'b0000));
    exp_q.push_back(mk(0, 0, 0, 0, -1, -1, -1, -1, 4'b0000));
    rst = 1'b0;
    wait_ps(n);
    chk("period_start delay after reset", n, 1);
    wait_ps(n);
    chk("period after reset", n, PER);
    wait_ps(n);
    chk("second period after reset", n, PER);
    repeat (5) @(negedge clk);
    chk("expectations drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
